mem_arbiter: RTL

- Shares the single memory port between instruction fetch (I-side) and the load/store path (D-side).
- The D-side is driven by the decoder's memread, memwrite and membyte controls.
- Sequences each access, performs byte-lane steering and sign extension for lb/sb, and flags misaligned word accesses and memory timeouts.
- The pipeline stalls on a requester until it receives its ack.

---
 rtl/mem_arbiter.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch (I) and load/store (D).
// Optional build macro MEM_ARB_FAIR_EN limits consecutive D grants while a fetch waits.
module mem_arbiter #(
    parameter int unsigned TIMEOUT    = 15,
    parameter int unsigned FAIR_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ack,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic        d_byte,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        d_err,
    output logic        mem_en,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    localparam int unsigned FW = $clog2(FAIR_LIMIT + 1);
    localparam logic [FW-1:0] FAIR_MAX = FW'(FAIR_LIMIT);

    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, ERR} state_t;

    function automatic logic [3:0] lane_mask(input logic [1:0] lane);
        case (lane)
            2'd0:    return 4'b0001;
            2'd1:    return 4'b0010;
            2'd2:    return 4'b0100;
            2'd3:    return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] load_byte(input logic [31:0] word, input logic [1:0] lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = 8'h00;
        endcase
        return {{24{b[7]}}, b};
    endfunction

    state_t        state_q, state_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [FW-1:0] fair_cnt_q, fair_cnt_d;
    logic          lat_byte_q, lat_byte_d;
    logic [1:0]    lat_lane_q, lat_lane_d;
    logic [31:0]   i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
    logic          i_ack_q, i_ack_d, i_err_q, i_err_d;
    logic          d_ack_q, d_ack_d, d_err_q, d_err_d;
    logic          mem_en_q, mem_en_d, mem_we_q, mem_we_d;
    logic [3:0]    mem_be_q, mem_be_d;
    logic [31:0]   mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic          d_misal_s;
    logic          fair_force_s;

    assign d_misal_s = !d_byte && (d_addr[1:0] != 2'b00);

`ifdef MEM_ARB_FAIR_EN
    assign fair_force_s = i_req && (fair_cnt_q == FAIR_MAX);
`else
    // Strict D priority: the fairness counter is held at zero and never consulted.
    assign fair_force_s = 1'b0 && (fair_cnt_q == FAIR_MAX);
`endif

    // Next-state, request latching and response generation.
    always_comb begin
        state_d     = state_q;
        to_cnt_d    = to_cnt_q;
        fair_cnt_d  = fair_cnt_q;
        lat_byte_d  = lat_byte_q;
        lat_lane_d  = lat_lane_q;
        i_rdata_d   = i_rdata_q;
        i_ack_d     = 1'b0;
        i_err_d     = 1'b0;
        d_rdata_d   = d_rdata_q;
        d_ack_d     = 1'b0;
        d_err_d     = 1'b0;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            IDLE: begin
                // The requester whose ack is on the wire still holds its request.
                if (i_ack_q || d_ack_q) begin
                    state_d = IDLE;
                end else if (d_req && !fair_force_s) begin
`ifdef MEM_ARB_FAIR_EN
                    fair_cnt_d = i_req ? (fair_cnt_q + FW'(1)) : {FW{1'b0}};
`endif
                    if (d_misal_s) begin
                        state_d = ERR;
                    end else begin
                        state_d     = GRANT_D;
                        to_cnt_d    = {TW{1'b0}};
                        lat_byte_d  = d_byte;
                        lat_lane_d  = d_addr[1:0];
                        mem_en_d    = 1'b1;
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr & 32'hFFFF_FFFC;
                        mem_be_d    = (d_we && d_byte) ? lane_mask(d_addr[1:0]) : 4'b1111;
                        mem_wdata_d = !d_we ? 32'h0000_0000 :
                                      (d_byte ? {4{d_wdata[7:0]}} : d_wdata);
                    end
                end else if (i_req) begin
                    state_d     = GRANT_I;
                    to_cnt_d    = {TW{1'b0}};
                    fair_cnt_d  = {FW{1'b0}};
                    mem_en_d    = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = i_addr & 32'hFFFF_FFFC;
                    mem_be_d    = 4'b1111;
                    mem_wdata_d = 32'h0000_0000;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT_I, GRANT_D: begin
                if (mem_ready) begin
                    state_d  = IDLE;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    if (state_q == GRANT_I) begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = mem_rdata;
                    end else begin
                        d_ack_d = 1'b1;
                        if (mem_we_q) begin
                            d_rdata_d = d_rdata_q;
                        end else if (lat_byte_q) begin
                            d_rdata_d = load_byte(mem_rdata, lat_lane_q);
                        end else begin
                            d_rdata_d = mem_rdata;
                        end
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    state_d  = IDLE;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    if (state_q == GRANT_I) begin
                        i_ack_d = 1'b1;
                        i_err_d = 1'b1;
                    end else begin
                        d_ack_d = 1'b1;
                        d_err_d = 1'b1;
                    end
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
            end
            ERR: begin
                state_d = IDLE;
                d_ack_d = 1'b1;
                d_err_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            to_cnt_q    <= {TW{1'b0}};
            fair_cnt_q  <= {FW{1'b0}};
            lat_byte_q  <= 1'b0;
            lat_lane_q  <= 2'b00;
            i_rdata_q   <= 32'h0000_0000;
            i_ack_q     <= 1'b0;
            i_err_q     <= 1'b0;
            d_rdata_q   <= 32'h0000_0000;
            d_ack_q     <= 1'b0;
            d_err_q     <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'b0000;
            mem_addr_q  <= 32'h0000_0000;
            mem_wdata_q <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            to_cnt_q    <= to_cnt_d;
            fair_cnt_q  <= fair_cnt_d;
            lat_byte_q  <= lat_byte_d;
            lat_lane_q  <= lat_lane_d;
            i_rdata_q   <= i_rdata_d;
            i_ack_q     <= i_ack_d;
            i_err_q     <= i_err_d;
            d_rdata_q   <= d_rdata_d;
            d_ack_q     <= d_ack_d;
            d_err_q     <= d_err_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign i_rdata   = i_rdata_q;
    assign i_ack     = i_ack_q;
    assign i_err     = i_err_q;
    assign d_rdata   = d_rdata_q;
    assign d_ack     = d_ack_q;
    assign d_err     = d_err_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
